// File: rtl/sseg_serial_ctrl.sv
// Serial seven-segment driver: shifts one segment byte per digit over
// a data/clock/latch 3-wire link to external shift-register boards.
module sseg_serial_ctrl #(
   parameter int NUM_DIGITS     = 8,
   parameter int REFRESH_DIV    = 200000,
   parameter int BIT_PERIOD     = 4,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int FAST_UPDATE    = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] din,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic                    raw_mode,
   input  logic [8*NUM_DIGITS-1:0] raw_seg,
   input  logic                    upd_valid,
   output logic                    upd_ready,
   output logic                    ss_dout,
   output logic                    ss_clk,
   output logic                    ss_en,
   output logic                    busy,
   output logic                    frame_done
);

   localparam int NBITS = 8 * NUM_DIGITS;
   localparam int BW    = $clog2(NBITS);
   localparam int RW    = $clog2(REFRESH_DIV);
   localparam int PW    = $clog2(BIT_PERIOD);
   localparam int DW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(BIT_PERIOD - 1);
   localparam logic [PW-1:0] PH_HALF  = PW'(BIT_PERIOD / 2);
   localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                  state_q, state_d;
   logic [RW-1:0]           ref_q, ref_d;
   logic [PW-1:0]           ph_q, ph_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic                    done_q, done_d;
   logic                    start;
   logic                    load;

   logic [4*NUM_DIGITS-1:0] din_q;
   logic [NUM_DIGITS-1:0]   dp_q;
   logic [NUM_DIGITS-1:0]   blank_q;
   logic                    raw_q;
   logic [8*NUM_DIGITS-1:0] raw_seg_q;

   logic [7:0]              seg_arr [NUM_DIGITS];
   logic [7:0]              seg;
   logic [DW-1:0]           dig;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      unique case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         4'hF: hex7 = 7'h71;
      endcase
   endfunction

   assign load = (state_q == IDLE) && upd_valid;

   always_comb begin
      state_d = state_q;
      ref_d   = ref_q;
      ph_d    = ph_q;
      bit_d   = bit_q;
      done_d  = 1'b0;
      start   = 1'b0;
      unique case (state_q)
         IDLE: begin
            start = (ref_q == REF_LAST) ||
                    ((FAST_UPDATE != 0) && upd_valid);
            if (start) begin
               state_d = SHIFT;
               ref_d   = '0;
               ph_d    = '0;
               bit_d   = '0;
            end else begin
               ref_d = ref_q + 1'b1;
            end
         end
         SHIFT: begin
            if (ph_q == PH_LAST) begin
               ph_d = '0;
               if (bit_q == BIT_LAST) begin
                  state_d = IDLE;
                  ref_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ref_q   <= '0;
         ph_q    <= '0;
         bit_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ref_q   <= ref_d;
         ph_q    <= ph_d;
         bit_q   <= bit_d;
         done_q  <= done_d;
      end
   end

   // Display stays dark until the first update arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_q     <= '0;
         dp_q      <= '0;
         blank_q   <= '1;
         raw_q     <= 1'b0;
         raw_seg_q <= '0;
      end else if (load) begin
         din_q     <= din;
         dp_q      <= dp;
         blank_q   <= blank;
         raw_q     <= raw_mode;
         raw_seg_q <= raw_seg;
      end
   end

   always_comb begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (raw_q)
            seg_arr[d] = raw_seg_q[8*d +: 8];
         else
            seg_arr[d] = {dp_q[d], hex7(din_q[4*d +: 4])};
         if (blank_q[d])
            seg_arr[d] = 8'h00;
         if (SEG_ACTIVE_LOW != 0)
            seg_arr[d] = ~seg_arr[d];
      end
   end

   assign dig = DW'(bit_q >> 3);
   assign seg = seg_arr[dig];

   // All pin outputs decode registered state only.
   assign ss_dout    = (state_q == SHIFT) && seg[~bit_q[2:0]];
   assign ss_clk     = (state_q == IDLE) || (ph_q >= PH_HALF);
   assign ss_en      = (state_q == IDLE);
   assign busy       = (state_q == SHIFT);
   assign upd_ready  = (state_q == IDLE);
   assign frame_done = done_q;

endmodule
